// File: rtl/multi_seq_if.sv
// Start/ready/valid handshake bundle for the multi_seq shift-add multiplier.
interface multi_seq_if #(
   parameter int WIDTH = 16
);
   logic                 in_start;
   logic                 in_sign;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_ready;
   logic                 out_valid;
   logic [2*WIDTH-1:0]   out_rlst;

   modport master (
      output in_start, in_sign, in_a, in_b,
      input  in_ready, out_valid, out_rlst
   );

   modport slave (
      input  in_start, in_sign, in_a, in_b,
      output in_ready, out_valid, out_rlst
   );
endinterface

// File: rtl/multi_seq.sv
// Sequential shift-add multiplier: WIDTH-bit signed/unsigned operands, one adder,
// WIDTH iterations on magnitudes with the sign applied once at the end.
module multi_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic         sclk,
   input  logic         rst_n,
   multi_seq_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                     state;
   state_t                     state_nxt;
   logic                       ready_c;
   logic                       accept;
   logic                       last_iter;
   logic [WIDTH-1:0]           mag_a;
   logic [WIDTH-1:0]           acc_hi;
   logic [WIDTH-1:0]           mplier;
   logic [CNT_W-1:0]           cnt;
   logic                       neg;
   logic [WIDTH:0]             sum;
   logic signed [2*WIDTH-1:0]  prod;
   logic                       valid_q;
   logic [2*WIDTH-1:0]         rlst_q;

   // |-2^(WIDTH-1)| still fits because the magnitude is kept unsigned
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic is_signed);
      magnitude = (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   function automatic logic signed [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                            input logic n);
      apply_sign = n ? -$signed(m) : $signed(m);
   endfunction

   assign accept    = (state == IDLE) && bus.in_start;
   assign last_iter = (cnt == CNT_W'(WIDTH-1));
   assign sum       = {1'b0, acc_hi} + {1'b0, (mplier[0] ? mag_a : {WIDTH{1'b0}})};
   assign prod      = apply_sign({acc_hi, mplier}, neg);

   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_c   = 1'b0;
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.in_start) state_nxt = CALC;
         end
         CALC:    if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, one shift-add per CALC cycle, signed result on DONE
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         mag_a   <= '0;
         acc_hi  <= '0;
         mplier  <= '0;
         cnt     <= '0;
         neg     <= 1'b0;
         valid_q <= 1'b0;
         rlst_q  <= '0;
      end else begin
         if (accept) begin
            mag_a  <= magnitude(bus.in_a, bus.in_sign);
            mplier <= magnitude(bus.in_b, bus.in_sign);
            acc_hi <= '0;
            cnt    <= '0;
            neg    <= bus.in_sign & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
         end else if (state == CALC) begin
            acc_hi <= sum[WIDTH:1];
            mplier <= {sum[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + 1'b1;
         end
         valid_q <= (state == DONE);
         if (state == DONE) rlst_q <= prod;
      end
   end

   assign bus.in_ready  = ready_c;
   assign bus.out_valid = valid_q;
   assign bus.out_rlst  = rlst_q;

endmodule

// File: tb/tb_multi_seq.sv
// Scoreboard bench for multi_seq: an abstract timing/product model pushes expectations,
// a negedge monitor pops and compares every strobe and watches ready/hold behaviour.
module tb_multi_seq;
   localparam int W = 16;

   typedef struct {
      logic [2*W-1:0] prod;
      int             acc;
   } exp_t;

   logic sclk;
   logic rst_n;
   int   checks;
   int   errors;
   int   cyc;
   int   busy;
   logic [2*W-1:0] last_rlst;
   logic           prev_valid;
   exp_t           exp_q[$];

   multi_seq_if #(.WIDTH(W)) bus ();

   multi_seq #(.WIDTH(W), .CNT_W(5)) dut (
      .sclk  (sclk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
      longint x;
      longint y;
      longint p;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      p = x * y;
      return p[2*W-1:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Behavioural model: an accepted op keeps the block busy for W+1 edges
   initial begin
      busy = 0;
      cyc  = 0;
      forever begin
         @(posedge sclk or negedge rst_n);
         if (!rst_n) begin
            busy = 0;
            exp_q.delete();
         end else begin
            cyc++;
            if (busy > 0) busy--;
            else if (bus.in_start) begin
               exp_q.push_back('{prod: ref_mul(bus.in_a, bus.in_b, bus.in_sign), acc: cyc});
               busy = W + 1;
            end
         end
      end
   end

   // Monitor
   initial begin
      exp_t e;
      last_rlst  = '0;
      prev_valid = 1'b0;
      forever begin
         @(negedge sclk);
         if (!rst_n) begin
            last_rlst  = '0;
            prev_valid = 1'b0;
         end else begin
            chk("in_ready", 64'(bus.in_ready), 64'(busy == 0));
            if (bus.out_valid) begin
               chk("valid_not_consecutive", 64'(prev_valid), 64'd0);
               if (exp_q.size() == 0) begin
                  chk("unexpected_valid", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("product", 64'(bus.out_rlst), 64'(e.prod));
                  chk("latency", 64'(cyc - e.acc), 64'(W + 1));
               end
               last_rlst = bus.out_rlst;
            end else begin
               chk("rlst_hold", 64'(bus.out_rlst), 64'(last_rlst));
               if (exp_q.size() != 0 && (cyc - exp_q[0].acc) >= W + 1) begin
                  chk("missing_valid", 64'd0, 64'd1);
                  void'(exp_q.pop_front());
               end
            end
            prev_valid = bus.out_valid;
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit noisy);
      int n;
      n = 0;
      @(negedge sclk);
      while (!bus.in_ready && n < 100) begin
         bus.in_start = noisy ? 1'($urandom_range(1)) : 1'b0;
         bus.in_a     = W'($urandom);
         bus.in_b     = W'($urandom);
         bus.in_sign  = 1'($urandom_range(1));
         @(negedge sclk);
         n++;
      end
      if (n >= 100) chk("ready_timeout", 64'd1, 64'd0);
      bus.in_start = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_sign  = s;
      @(negedge sclk);
      bus.in_start = 1'b0;
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      bus.in_sign  = 1'($urandom_range(1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || busy != 0) && n < 200) begin
         @(negedge sclk);
         n++;
      end
      if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
      @(negedge sclk);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [2*W-1:0] want, input string name);
      issue(a, b, s, 1'b0);
      drain();
      chk(name, 64'(last_rlst), 64'(want));
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      rst_n        = 1'b0;
      bus.in_start = 1'b0;
      bus.in_sign  = 1'b0;
      bus.in_a     = '0;
      bus.in_b     = '0;
      #3;
      chk("rst_rlst", 64'(bus.out_rlst), 64'd0);
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd1);
      repeat (3) @(negedge sclk);
      rst_n = 1'b1;

      run_op(16'd3, 16'd5, 1'b0, 32'h0000000F, "u_3x5");
      run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u_max");
      run_op(16'h0000, 16'hFFFF, 1'b0, 32'h00000000, "u_zero");
      run_op(16'h0001, 16'h8000, 1'b0, 32'h00008000, "u_1x8000");
      run_op(16'hFFFD, 16'd7, 1'b1, 32'hFFFFFFEB, "s_m3x7");
      run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "s_m1xm1");
      run_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s_min_sq");
      run_op(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "s_minxmax");
      run_op(16'h0000, 16'h8000, 1'b1, 32'h00000000, "s_zero_neg");

      // Back-to-back: start held high, operands switch to 4*5 after the first accept
      @(negedge sclk);
      bus.in_start = 1'b1;
      bus.in_sign  = 1'b0;
      bus.in_a     = 16'd2;
      bus.in_b     = 16'd3;
      @(negedge sclk);
      bus.in_a = 16'd4;
      bus.in_b = 16'd5;
      repeat (18) @(negedge sclk);
      bus.in_start = 1'b0;
      drain();
      chk("b2b_second", 64'(last_rlst), 64'd20);

      // Reset in the middle of CALC
      issue(16'd100, 16'd200, 1'b0, 1'b0);
      repeat (7) @(negedge sclk);
      @(posedge sclk);
      rst_n = 1'b0;
      #1;
      chk("abort_rlst", 64'(bus.out_rlst), 64'd0);
      chk("abort_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_ready", 64'(bus.in_ready), 64'd1);
      repeat (2) @(negedge sclk);
      rst_n = 1'b1;
      run_op(16'd7, 16'd9, 1'b0, 32'd63, "after_abort");

      // Random regression with spurious starts while busy
      for (int i = 0; i < 255; i++) begin
         issue(W'($urandom % 32768), W'($urandom % 32768), 1'($urandom_range(1)), 1'b1);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1);
   end
endmodule

// File: doc/multi_seq.md
# multi_seq

Parametrised sequential shift-add multiplier, the successor to the single-cycle `multi` block. It multiplies two WIDTH-bit operands, signed or unsigned selectable per operation, over WIDTH+1 clock cycles using one adder instead of a full array. A start/ready/valid handshake lets upstream logic issue operations and capture each 2*WIDTH-bit product on a one-cycle valid strobe. It is intended for datapaths where area matters more than throughput.

## Interface
- `WIDTH`, default 16: operand width in bits, minimum 2; the product is 2*WIDTH bits.
- `CNT_W`, default 5: iteration counter width; must satisfy 2^CNT_W > WIDTH.

- `sclk`  input  1  system clock, all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_start`  input  1  request; accepted when high while `in_ready` is high.
- `in_sign`  input  1  1 = operands are two's complement; 0 = unsigned. Sampled with `in_start`.
- `in_a`  input  WIDTH  multiplicand, sampled on acceptance.
- `in_b`  input  WIDTH  multiplier, sampled on acceptance.
- `in_ready`  output  1  high in IDLE; the block can accept `in_start`.
- `out_valid`  output  1  one-cycle strobe; `out_rlst` holds a new product.
- `out_rlst`  output  2*WIDTH  product; holds its value until the next `out_valid`.

## Operation
- States: IDLE, CALC, DONE. `in_ready` = (state == IDLE).
- IDLE + `in_start`=1:
  - Latch the sign flag.
  - Latch mag_a = |in_a| and mag_b = |in_b| when signed; otherwise the raw values.
  - Latch neg = in_sign & (a[MSB] ^ b[MSB]).
  - Clear the accumulator and counter.
  - Go to CALC.
- IDLE + `in_start`=0: stay in IDLE; no state changes.
- CALC, one iteration per cycle:
  - acc_hi = acc_hi + (mplier[0] ? mag_a : 0), computed with a WIDTH+1-bit carry.
  - Shift {carry, acc_hi, mplier} right by 1.
  - Increment the counter.
  - After WIDTH iterations (counter == WIDTH-1 at the edge), go to DONE.
- DONE:
  - `out_rlst` <= neg ? -{acc_hi, mplier} : {acc_hi, mplier}, as a 2*WIDTH-bit two's complement result.
  - `out_valid` <= 1.
  - Go to IDLE.
- Magnitude rule: |-2^(WIDTH-1)| = 2^(WIDTH-1) is held as a WIDTH-bit unsigned value, so there is no overflow. (-2^(W-1))^2 = 2^(2W-2) fits in the signed 2W-bit result.
- A zero operand gives a zero result. neg may be 1 in that case, and -0 = 0.
- `in_start` while not in IDLE is ignored entirely; the operation in flight is unaffected. There is no queueing.
- `in_a`, `in_b` and `in_sign` may change freely after acceptance.

## Timing
- Reset (async assert, released synchronously by the system):
  - state = IDLE, `in_ready`=1, `out_valid`=0, `out_rlst`=0.
  - Accumulator, multiplier register, counter and neg all 0.
- Acceptance at edge E. CALC edges run from E+1 to E+WIDTH. The DONE edge is E+WIDTH+1, after which `out_valid`=1 for exactly one cycle and `out_rlst` is updated.
- Latency: WIDTH+1 cycles from the accepting edge to valid (17 for WIDTH=16).
- `in_ready` is low from after E through the cycle in which `out_valid` is high. It returns high after edge E+WIDTH+1.
- The earliest next acceptance is edge E+WIDTH+2, giving an issue interval of WIDTH+2 cycles (18 for WIDTH=16).
- Reset asserted mid-CALC or mid-DONE aborts the operation immediately. No `out_valid` is produced, and `out_rlst` returns to 0.
- `out_valid` is never high in two consecutive cycles.

## Test plan
- Unsigned basic, WIDTH=16: start with a=3, b=5, sign=0 at edge E. Required: `out_valid` after edge E+17, `out_rlst`=0x0000000F, `in_ready` low for 17 cycles.
- Unsigned extremes:
  - a=b=0xFFFF gives 0xFFFE0001.
  - a=0, b=0xFFFF gives 0.
  - a=1, b=0x8000 gives 0x00008000.
- Signed:
  - a=-3 (0xFFFD), b=7 gives 0xFFFFFFEB.
  - a=b=0xFFFF gives 0x00000001.
  - a=b=0x8000 gives 0x40000000.
  - a=0x8000, b=0x7FFF gives 0xC0008000.
- Busy/back-to-back:
  - Start 2*3, then hold `in_start`=1 continuously with new operands 4*5. Required: first result 6, the second start accepted only at E+18, second result 20 after E+35.
  - Starts issued during CALC are ignored.
- Reset mid-operation: start 100*200 and assert `rst_n`=0 at E+8. Required: `out_rlst`=0, `out_valid`=0, `in_ready`=1 immediately. After release, start 7*9 produces 63 with normal latency.
- Random regression: 255 operations with `{$random} % 32768` operands and random sign. Required: every `out_rlst` matches the behavioural product, and `out_rlst` holds steady between strobes.
